// File: rtl/time_seg_fmt.sv
// ----------------------------------------------------------------------------
// time_seg_fmt
//   Formats hour/min/sec binary fields into the six-digit 7-segment bus and
//   the decimal-point bus used by the multiplexed LED display driver.
//   Two registered stages: stage 1 splits each field into tens/units and
//   flags out-of-range values; stage 2 encodes the segment patterns and
//   blanks the field under adjustment while the blink phase is off.
//
// Optional feature macro: TIME_SEG_DP_BLINK_EN
//   defined   : separator DPs (bits 4 and 2) follow the blink phase
//   undefined : DPs are constant 6'b010100 outside reset
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous reset, active-high
//   i_sec[5:0]       seconds 0..59
//   i_min[5:0]       minutes 0..59
//   i_hour[5:0]      hours 0..23
//   i_blink_sel[1:0] blinking field: 0 none, 1 sec, 2 min, 3 hour
//   o_six_digit_seg  {hour-tens, hour-units, min-tens, min-units,
//                     sec-tens, sec-units}, 7 bits each, {a..g} a = MSB
//   o_six_dp[5:0]    decimal point per digit, same order, 1 = lit
// ----------------------------------------------------------------------------
module time_seg_fmt #(
    parameter int BLINK_HALF = 25000000,
    parameter int CNT_W      = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_sec,
    input  logic [5:0]  i_min,
    input  logic [5:0]  i_hour,
    input  logic [1:0]  i_blink_sel,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_HALF - 1);
    localparam logic [6:0]       SEG_DASH  = 7'b0000001;
    localparam logic [6:0]       SEG_BLANK = 7'b0000000;
    localparam logic [5:0]       DP_SEP    = 6'b010100;

    // Digit to {a,b,c,d,e,f,g} pattern.
    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1111110;
            4'd1:    p = 7'b0110000;
            4'd2:    p = 7'b1101101;
            4'd3:    p = 7'b1111001;
            4'd4:    p = 7'b0110011;
            4'd5:    p = 7'b1011011;
            4'd6:    p = 7'b1011111;
            4'd7:    p = 7'b1110000;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1111011;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // Split a 6-bit value into {tens[2:0], units[3:0]}; tens never exceeds 6.
    function automatic logic [6:0] split10(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] u;
        t = v / 6'd10;
        u = v % 6'd10;
        return {t[2:0], u[3:0]};
    endfunction

    // Two-digit pattern for one field: dash on out-of-range, blank wins over all.
    function automatic logic [13:0] field_pat(input logic [2:0] tens,
                                              input logic [3:0] units,
                                              input logic       oor,
                                              input logic       blank);
        logic [13:0] p;
        if (blank) begin
            p = {SEG_BLANK, SEG_BLANK};
        end else if (oor) begin
            p = {SEG_DASH, SEG_DASH};
        end else begin
            p = {enc7({1'b0, tens}), enc7(units)};
        end
        return p;
    endfunction

    // Blink state and stored select
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             phase_q, phase_d;
    logic [1:0]       sel_q,   sel_d;
    // Stage 1
    logic [2:0]       sec_t_q,  sec_t_d,  min_t_q,  min_t_d,  hour_t_q,  hour_t_d;
    logic [3:0]       sec_u_q,  sec_u_d,  min_u_q,  min_u_d,  hour_u_q,  hour_u_d;
    logic             sec_oor_q, sec_oor_d, min_oor_q, min_oor_d, hour_oor_q, hour_oor_d;
    // Stage 2
    logic [41:0]      seg_q, seg_d;
    logic [5:0]       dp_q,  dp_d;

    // Blink counter: a select change restarts a visible half-period and wins over wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        sel_d   = i_blink_sel;
        if (i_blink_sel != sel_q) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stage 1: tens/units split and range flags.
    always_comb begin
        {sec_t_d,  sec_u_d}  = split10(i_sec);
        {min_t_d,  min_u_d}  = split10(i_min);
        {hour_t_d, hour_u_d} = split10(i_hour);
        sec_oor_d  = (i_sec  > 6'd59);
        min_oor_d  = (i_min  > 6'd59);
        hour_oor_d = (i_hour > 6'd23);
    end

    // Stage 2: encode, blank the selected field during the off phase, drive DPs.
    always_comb begin
        seg_d = {field_pat(hour_t_q, hour_u_q, hour_oor_q, (sel_q == 2'd3) && !phase_q),
                 field_pat(min_t_q,  min_u_q,  min_oor_q,  (sel_q == 2'd2) && !phase_q),
                 field_pat(sec_t_q,  sec_u_q,  sec_oor_q,  (sel_q == 2'd1) && !phase_q)};
`ifdef TIME_SEG_DP_BLINK_EN
        dp_d  = phase_q ? DP_SEP : 6'b000000;
`else
        dp_d  = DP_SEP;
`endif
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= {CNT_W{1'b0}};
            phase_q    <= 1'b1;
            sel_q      <= 2'd0;
            sec_t_q    <= 3'd0;
            sec_u_q    <= 4'd0;
            min_t_q    <= 3'd0;
            min_u_q    <= 4'd0;
            hour_t_q   <= 3'd0;
            hour_u_q   <= 4'd0;
            sec_oor_q  <= 1'b0;
            min_oor_q  <= 1'b0;
            hour_oor_q <= 1'b0;
            seg_q      <= {6{7'b1111110}};
            dp_q       <= 6'b000000;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            sel_q      <= sel_d;
            sec_t_q    <= sec_t_d;
            sec_u_q    <= sec_u_d;
            min_t_q    <= min_t_d;
            min_u_q    <= min_u_d;
            hour_t_q   <= hour_t_d;
            hour_u_q   <= hour_u_d;
            sec_oor_q  <= sec_oor_d;
            min_oor_q  <= min_oor_d;
            hour_oor_q <= hour_oor_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign o_six_digit_seg = seg_q;
    assign o_six_dp        = dp_q;

endmodule
